// File: rtl/bfu_pipe_modq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bfu_pipe_modq
//  Purpose  : Three-stage pipelined modular butterfly for the NTT/INTT path.
//             Each operand set selects a Cooley-Tukey (forward) or a
//             Gentleman-Sande (inverse) butterfly mod Q. The block has a
//             valid/ready handshake with backpressure, carries a sideband tag
//             and flags out-of-range operands with a sticky error.
//  Revision : 1.0 - initial pipelined release
// ----------------------------------------------------------------------------
//  Parameters
//    DW     operand/result width; x, y, w and Q all fit in DW bits
//    Q      prime modulus, 2 < Q < 2**DW, fixed at compile time
//    TAG_W  width of the sideband tag
//  Ports
//    clk        rising-edge clock
//    reset      asynchronous, active-low reset
//    in_valid   operand set valid          in_ready   set accepted this cycle
//    mode       0 = CT (forward), 1 = GS (inverse), sampled with operands
//    xin/yin/wr operands x, y and twiddle w (each expected < Q)
//    tag_in     sideband tag, returned unchanged with the result
//    out_valid  result valid               out_ready  downstream accepts
//    xout/yout  results x' and y'          tag_out    tag of the result
//    err        sticky: an accepted operand was >= Q
//  Build option
//    HALF_SCALE_EN  when defined, GS results are multiplied by 2^-1 mod Q
//                   inside the last stage; CT results and latency unchanged.
// ============================================================================
module bfu_pipe_modq #(
    parameter int unsigned   DW    = 32,
    parameter logic [DW-1:0] Q     = DW'(2013265921),
    parameter int unsigned   TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [DW-1:0]    xin,
    input  logic [DW-1:0]    yin,
    input  logic [DW-1:0]    wr,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    xout,
    output logic [DW-1:0]    yout,
    output logic [TAG_W-1:0] tag_out,
    output logic             err
);

    // Modulus widened by one bit for the add/sub/halve carries.
    localparam logic [DW:0] c_q_ext = {1'b0, Q};

    // ------------------------------------------------------------------
    // Modular arithmetic helpers
    // ------------------------------------------------------------------
    function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= c_q_ext) begin
            s = s - c_q_ext;
        end
        return s[DW-1:0];
    endfunction

    // A borrow shows up as the extra top bit; adding Q folds it back.
    function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [DW:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[DW]) begin
            d = d + c_q_ext;
        end
        return d[DW-1:0];
    endfunction

    // Full 2*DW product reduced by a constant-modulus remainder.
    function automatic logic [DW-1:0] mod_mul(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [2*DW-1:0] prod;
        logic [2*DW-1:0] rem;
        prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        rem  = prod % {{DW{1'b0}}, Q};
        return rem[DW-1:0];
    endfunction

`ifdef HALF_SCALE_EN
    // v * 2^-1 mod Q: even values shift, odd values add Q first (DW+1 bits).
    function automatic logic [DW-1:0] mod_half(input logic [DW-1:0] v);
        return DW'(({1'b0, v} + (v[0] ? c_q_ext : '0)) >> 1);
    endfunction
`endif

    // ------------------------------------------------------------------
    // Handshake: the whole pipe freezes when the output is blocked.
    // Bubbles are not squeezed out, so every stage shares one enable.
    // ------------------------------------------------------------------
    logic stall;
    logic adv;
    logic accept;

    // Stage 1: registered operands
    logic             v1_q, m1_q;
    logic [TAG_W-1:0] t1_q;
    logic [DW-1:0]    x1_q, y1_q, w1_q;

    // Stage 2: CT -> a = x, b = w*y ; GS -> a = x+y, b = x-y, w kept
    logic             v2_q, m2_q;
    logic [TAG_W-1:0] t2_q;
    logic [DW-1:0]    a2_q, b2_q, w2_q;
    logic [DW-1:0]    a2_d, b2_d;

    // Stage 3: results
    logic             v3_q;
    logic [TAG_W-1:0] t3_q;
    logic [DW-1:0]    x3_q, y3_q;
    logic [DW-1:0]    x3_d, y3_d;

    logic             err_q;
    logic             range_bad;

    assign stall     = v3_q & ~out_ready;
    assign adv       = ~stall;
    assign in_ready  = adv;
    assign accept    = in_valid & adv;
    assign range_bad = (xin >= Q) | (yin >= Q) | (wr >= Q);

    always_comb begin
        a2_d = x1_q;
        b2_d = mod_mul(w1_q, y1_q);
        if (m1_q) begin
            a2_d = mod_add(x1_q, y1_q);
            b2_d = mod_sub(x1_q, y1_q);
        end
    end

    always_comb begin
        x3_d = mod_add(a2_q, b2_q);
        y3_d = mod_sub(a2_q, b2_q);
        if (m2_q) begin
`ifdef HALF_SCALE_EN
            x3_d = mod_half(a2_q);
            y3_d = mod_half(mod_mul(b2_q, w2_q));
`else
            x3_d = a2_q;
            y3_d = mod_mul(b2_q, w2_q);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q <= 1'b0;
            m1_q <= 1'b0;
            t1_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
            w1_q <= '0;
            v2_q <= 1'b0;
            m2_q <= 1'b0;
            t2_q <= '0;
            a2_q <= '0;
            b2_q <= '0;
            w2_q <= '0;
            v3_q <= 1'b0;
            t3_q <= '0;
            x3_q <= '0;
            y3_q <= '0;
        end else if (adv) begin
            v1_q <= in_valid;
            m1_q <= mode;
            t1_q <= tag_in;
            x1_q <= xin;
            y1_q <= yin;
            w1_q <= wr;
            v2_q <= v1_q;
            m2_q <= m1_q;
            t2_q <= t1_q;
            a2_q <= a2_d;
            b2_q <= b2_d;
            w2_q <= w1_q;
            v3_q <= v2_q;
            t3_q <= t2_q;
            x3_q <= x3_d;
            y3_q <= y3_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (accept && range_bad) begin
            err_q <= 1'b1;
        end
    end

    assign out_valid = v3_q;
    assign xout      = x3_q;
    assign yout      = y3_q;
    assign tag_out   = t3_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bfu_pipe_modq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bfu_pipe_modq
//  Purpose  : Directed self-checking bench for bfu_pipe_modq (DW=8, Q=17).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bfu_pipe_modq;

    localparam int          DW    = 8;
    localparam int          TAG_W = 4;
    localparam int          QI    = 17;
    localparam logic [7:0]  QV    = 8'd17;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [DW-1:0]    xin, yin, wr;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    xout, yout;
    logic [TAG_W-1:0] tag_out;
    logic             err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bfu_pipe_modq #(.DW(DW), .Q(QV), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .xin       (xin),
        .yin       (yin),
        .wr        (wr),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xout      (xout),
        .yout      (yout),
        .tag_out   (tag_out),
        .err       (err)
    );

    // Reference butterfly, straight from the arithmetic definition.
    function automatic void model(input logic m, input int x, input int y, input int w,
                                  output int ex, output int ey);
        int p;
        if (!m) begin
            p  = (w * y) % QI;
            ex = (x + p) % QI;
            ey = (x - p + QI) % QI;
        end else begin
            ex = (x + y) % QI;
            ey = (((x - y + QI) % QI) * w) % QI;
`ifdef HALF_SCALE_EN
            ex = (ex % 2 == 1) ? (ex + QI) / 2 : ex / 2;
            ey = (ey % 2 == 1) ? (ey + QI) / 2 : ey / 2;
`endif
        end
    endfunction

    // Send one set into an empty pipe and check latency, data and tag.
    task automatic send_one(input logic m, input int x, input int y, input int w,
                            input int t, input int ex, input int ey, input string nm);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        mode      = m;
        xin       = DW'(x);
        yin       = DW'(y);
        wr        = DW'(w);
        tag_in    = TAG_W'(t);
        in_valid  = 1'b1;
        lat       = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 8);
        n_tests++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, expected 3", nm, lat);
        end
        n_tests++;
        if (out_valid !== 1'b1 || xout !== DW'(ex) || yout !== DW'(ey) || tag_out !== TAG_W'(t)) begin
            n_fail++;
            $display("FAIL %s data: got v=%0b x=%0d y=%0d tag=%0d, expected v=1 x=%0d y=%0d tag=%0d",
                     nm, out_valid, xout, yout, tag_out, ex, ey, t);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode      = 1'b0;
        xin       = '0;
        yin       = '0;
        wr        = '0;
        tag_in    = '0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || xout !== 8'd0 || yout !== 8'd0 || tag_out !== 4'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%0b x=%0d y=%0d tag=%0d err=%0b, expected all 0",
                     out_valid, xout, yout, tag_out, err);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%0b out_valid=%0b, expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_ct_basic();
        send_one(1'b0, 3, 5, 2, 4'd5, 13, 10, "ct_basic");
    endtask

    task automatic test_gs_basic();
`ifdef HALF_SCALE_EN
        send_one(1'b1, 3, 5, 2, 4'd9, 4, 15, "gs_basic");
`else
        send_one(1'b1, 3, 5, 2, 4'd9, 8, 13, "gs_basic");
`endif
    endtask

    task automatic test_boundaries();
        send_one(1'b0, 0, 16, 16, 4'd1, 1, 16, "ct_boundary");
`ifdef HALF_SCALE_EN
        send_one(1'b1, 16, 16, 16, 4'd2, 16, 0, "gs_boundary");
`else
        send_one(1'b1, 16, 16, 16, 4'd2, 15, 0, "gs_boundary");
`endif
    endtask

    // 20 mixed sets back to back; out_ready low for cycles 6..10.
    task automatic test_back_to_back();
        int ex_q[$];
        int ey_q[$];
        int et_q[$];
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        int ex, ey, et, x, y, w;
        logic m;
        logic prev_stall = 1'b0;
        logic [DW-1:0] px = '0, py = '0;
        logic [TAG_W-1:0] pt = '0;
        bit extra = 1'b0;
        while (got < 20 && cyc < 200) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 10);
            #1;
            if (out_valid && !out_ready) begin
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_ready cyc %0d: got %0b, expected 0", cyc, in_ready);
                end
                if (prev_stall) begin
                    n_tests++;
                    if (xout !== px || yout !== py || tag_out !== pt) begin
                        n_fail++;
                        $display("FAIL stall_hold cyc %0d: got x=%0d y=%0d tag=%0d, expected x=%0d y=%0d tag=%0d",
                                 cyc, xout, yout, tag_out, px, py, pt);
                    end
                end
                prev_stall = 1'b1;
                px = xout;
                py = yout;
                pt = tag_out;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (ex_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: got x=%0d y=%0d tag=%0d, expected no result", xout, yout, tag_out);
                end else begin
                    ex = ex_q.pop_front();
                    ey = ey_q.pop_front();
                    et = et_q.pop_front();
                    if (xout !== DW'(ex) || yout !== DW'(ey) || tag_out !== TAG_W'(et)) begin
                        n_fail++;
                        $display("FAIL stream_data #%0d: got x=%0d y=%0d tag=%0d, expected x=%0d y=%0d tag=%0d",
                                 got, xout, yout, tag_out, ex, ey, et);
                    end
                    got++;
                end
            end
            if (sent < 20 && in_ready) begin
                m = 1'($urandom_range(0, 1));
                x = int'($urandom_range(0, QI - 1));
                y = int'($urandom_range(0, QI - 1));
                w = int'($urandom_range(0, QI - 1));
                model(m, x, y, w, ex, ey);
                ex_q.push_back(ex);
                ey_q.push_back(ey);
                et_q.push_back(sent % 16);
                mode     = m;
                xin      = DW'(x);
                yin      = DW'(y);
                wr       = DW'(w);
                tag_in   = TAG_W'(sent % 16);
                in_valid = 1'b1;
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_tests++;
        if (got !== 20) begin
            n_fail++;
            $display("FAIL stream_count: got %0d results, expected 20", got);
        end
        repeat (4) begin
            @(negedge clk);
            if (out_valid) extra = 1'b1;
        end
        n_tests++;
        if (extra) begin
            n_fail++;
            $display("FAIL stream_tail: got an extra out_valid after the stream, expected none");
        end
    endtask

    task automatic test_range_err();
        @(negedge clk);
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_before: got %0b, expected 0", err);
        end
        out_ready = 1'b1;
        mode      = 1'b0;
        xin       = 8'd3;
        yin       = 8'd17;
        wr        = 8'd2;
        tag_in    = 4'd7;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got %0b, expected 1", err);
        end
        repeat (4) @(negedge clk);
        send_one(1'b0, 3, 5, 2, 4'd3, 13, 10, "after_err_ct");
        send_one(1'b1, 16, 16, 16, 4'd4,
`ifdef HALF_SCALE_EN
                 16, 0,
`else
                 15, 0,
`endif
                 "after_err_gs");
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %0b, expected 1", err);
        end
    endtask

    task automatic test_reset_inflight();
        bit stale = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mode     = i[0];
            xin      = DW'(i + 1);
            yin      = DW'(i + 2);
            wr       = DW'(i + 3);
            tag_in   = TAG_W'(i + 10);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL inflight_full: got out_valid=%0b, expected 1", out_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || err !== 1'b0 || xout !== 8'd0 || yout !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%0b err=%0b x=%0d y=%0d, expected all 0",
                     out_valid, err, xout, yout);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        n_tests++;
        if (stale) begin
            n_fail++;
            $display("FAIL stale_after_reset: got out_valid=1, expected 0");
        end
        send_one(1'b0, 0, 16, 16, 4'd6, 1, 16, "post_reset");
    endtask

    initial begin
        test_reset();
        test_ct_basic();
        test_gs_basic();
        test_boundaries();
        test_back_to_back();
        test_range_err();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
